argmax_classifier: RTL and testbench
====================================

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 N_CLASS, default 7: number of class scores per result, legal range 1..64.
REQ-002 DATA_BITS, default 8: width of each class score.
REQ-003 SIGNED, default 1: 1 compares scores as two's complement; 0 compares them as unsigned.
REQ-004 STICKY, default 1: 1 ORs each new class LED into led_o; 0 makes each result replace the class LEDs.
REQ-005 CLS_W, derived: max(1, ceil(log2(N_CLASS))).
REQ-006 clk  in  1  sole clock; all logic on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 valid_i  in  1  score vector present on data_i.
REQ-009 data_i  in  N_CLASS*DATA_BITS  class k score at [k*DATA_BITS +: DATA_BITS].
REQ-010 clear_i  in  1  clears led_o.
REQ-011 ready_o  out  1  block can accept a vector; high only in IDLE.
REQ-012 valid_o  out  1  one-cycle pulse marking a new result.
REQ-013 class_o  out  CLS_W  index of the winning class.
REQ-014 max_o  out  DATA_BITS  winning score.
REQ-015 onehot_o  out  N_CLASS  bit k set when class k won the last result.
REQ-016 led_o  out  N_CLASS+1  bit N_CLASS: sticky "a result exists"; bit N_CLASS-1-k: class k.
REQ-017 result_cnt_o  out  16  count of completed results, saturating at 0xFFFF.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-019 In IDLE with valid_i=1, the block SHALL register all of data_i, load best=score0, idx=0, i=1, and go to SCAN (go directly to DONE if N_CLASS=1).
REQ-020 In IDLE with valid_i=0, the block SHALL stay in IDLE and leave every output unchanged.
REQ-021 In SCAN, each cycle SHALL compare score i to best and update best/idx only on strictly-greater, then increment i.
REQ-022 Tie-break SHALL be lowest index wins.
REQ-023 SCAN SHALL go to DONE after the cycle that compares i=N_CLASS-1.
REQ-024 In DONE for one cycle, the block SHALL assert valid_o and load class_o, max_o and onehot_o.
REQ-025 In that DONE cycle, the block SHALL set led_o[N_CLASS], update the class LEDs per STICKY, increment result_cnt_o, and return to IDLE.
REQ-026 Latency: a vector accepted at cycle t SHALL produce valid_o at cycle t+N_CLASS.
REQ-027 The next vector SHALL be accepted no earlier than t+N_CLASS+1.
REQ-028 valid_i while ready_o=0 SHALL be ignored; data_i changes after acceptance SHALL not affect the result.
REQ-029 class_o, max_o and onehot_o SHALL hold their values until the next DONE.
REQ-030 clear_i SHALL zero led_o on the next edge in any state, without affecting the FSM or the other outputs.
REQ-031 When clear_i and DONE coincide, led_o SHALL equal only the new result (done bit plus the winning class bit).
REQ-032 Comparison SHALL be a full-width DATA_BITS compare with no truncation; the comparator polarity SHALL follow SIGNED.
REQ-033 result_cnt_o SHALL not wrap: at 0xFFFF it stays 0xFFFF.

Reset
REQ-034 reset=1 SHALL force IDLE, ready_o=1 and valid_o=0 on the next edge.
REQ-035 reset=1 SHALL zero class_o, max_o, onehot_o, led_o, result_cnt_o and all internal registers on the next edge.
REQ-036 reset during SCAN or DONE SHALL abort the scan and SHALL produce no valid_o for the aborted vector.
REQ-037 reset SHALL take priority over valid_i and clear_i.

Structure
REQ-038 State encoding localparams and the CLS_W ceil-log2 function SHALL live in the shared package cnn_pkg.
REQ-039 The signed/unsigned greater-than compare SHALL be one combinational sub-module, argmax_cmp (parameters DATA_BITS, SIGNED), instantiated once.
REQ-040 Score storage SHALL be one N_CLASS*DATA_BITS register, indexed by i; there SHALL be no N-way parallel comparator tree.

Verification (N_CLASS=7, DATA_BITS=8 unless stated)
REQ-041 SIGNED=1, scores 10,20,5,-3,20,0,1 at t -> valid_o at t+7, class_o=1 (tie with class 4), max_o=0x14, onehot_o=7'b0000010, led_o=8'b1010_0000.
REQ-042 All scores 0x80 -> class_o=0, max_o=0x80.
REQ-043 Scores 0x7F except class3=0x80 -> SIGNED=0 gives class_o=3; SIGNED=1 gives class_o=0.
REQ-044 STICKY=1, results class1 then class6 -> led_o=8'b1010_0001; clear_i pulse -> led_o=0. Same sequence with STICKY=0 -> led_o=8'b1000_0001 after the second result.
REQ-045 valid_i held high through a scan with changing data_i -> exactly one valid_o per 8 cycles; each result matches the vector captured when ready_o was high.
REQ-046 reset at t+3 of a scan -> valid_o stays low, all outputs 0 and ready_o=1 from t+4; N_CLASS=1 run gives valid_o at t+1 with class_o=0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN post-processing blocks.
// Holds the argmax FSM state encoding and the class-index width function.
package cnn_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Class index width: ceil(log2(n)), never less than one bit.
  function automatic int unsigned cls_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Single greater-than comparator shared by the argmax scan.
// SIGNED selects two's complement or unsigned ordering.
module argmax_cmp #(
  parameter int unsigned DATA_BITS = 8,
  parameter bit          SIGNED    = 1'b1
) (
  input  logic [DATA_BITS-1:0] a_i,
  input  logic [DATA_BITS-1:0] b_i,
  output logic                 gt_o
);

  always_comb begin
    if (SIGNED) gt_o = $signed(a_i) > $signed(b_i);
    else        gt_o = a_i > b_i;
  end

endmodule

// File: rtl/argmax_classifier.sv
// Sequential argmax over N_CLASS scores: one comparison per cycle against the
// captured score vector, then a one-cycle result pulse with LED/counter update.
module argmax_classifier
  import cnn_pkg::*;
#(
  parameter  int unsigned N_CLASS   = 7,
  parameter  int unsigned DATA_BITS = 8,
  parameter  bit          SIGNED    = 1'b1,
  parameter  bit          STICKY    = 1'b1,
  localparam int unsigned CLS_W     = cls_width(N_CLASS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid_i,
  input  logic [N_CLASS*DATA_BITS-1:0]   data_i,
  input  logic                           clear_i,
  output logic                           ready_o,
  output logic                           valid_o,
  output logic [CLS_W-1:0]               class_o,
  output logic [DATA_BITS-1:0]           max_o,
  output logic [N_CLASS-1:0]             onehot_o,
  output logic [N_CLASS:0]               led_o,
  output logic [15:0]                    result_cnt_o
);

  localparam logic [CLS_W-1:0] LAST = CLS_W'(N_CLASS - 1);

  state_t                                state_q;
  logic [N_CLASS-1:0][DATA_BITS-1:0]     scores_q;
  logic [DATA_BITS-1:0]                  best_q, best_d;
  logic [CLS_W-1:0]                      idx_q, idx_d;
  logic [CLS_W-1:0]                      i_q;
  logic                                  valid_q;
  logic [CLS_W-1:0]                      class_q;
  logic [DATA_BITS-1:0]                  max_q;
  logic [N_CLASS-1:0]                    onehot_q, onehot_d;
  logic [N_CLASS:0]                      led_q, led_d, led_keep;
  logic [N_CLASS-1:0]                    led_cls;
  logic [15:0]                           cnt_q;
  logic                                  gt;

  argmax_cmp #(
    .DATA_BITS(DATA_BITS),
    .SIGNED   (SIGNED)
  ) u_cmp (
    .a_i (scores_q[i_q]),
    .b_i (best_q),
    .gt_o(gt)
  );

  // Strictly-greater update keeps the lowest index on ties.
  always_comb begin
    best_d = gt ? scores_q[i_q] : best_q;
    idx_d  = gt ? i_q : idx_q;
  end

  // Class LEDs are bit-reversed relative to the one-hot result.
  always_comb begin
    onehot_d        = '0;
    onehot_d[idx_q] = 1'b1;
    led_cls         = '0;
    for (int unsigned k = 0; k < N_CLASS; k++) led_cls[N_CLASS-1-k] = onehot_d[k];
  end

  // A coincident clear wipes the history first, so only the new result shows.
  always_comb begin
    led_keep = clear_i ? '0 : led_q;
    if (state_q == S_DONE)
      led_d = {1'b1, (STICKY ? led_keep[N_CLASS-1:0] : '0) | led_cls};
    else
      led_d = led_keep;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      scores_q <= '0;
      best_q   <= '0;
      idx_q    <= '0;
      i_q      <= '0;
      valid_q  <= 1'b0;
      class_q  <= '0;
      max_q    <= '0;
      onehot_q <= '0;
      led_q    <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      led_q   <= led_d;
      unique case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            scores_q <= data_i;
            best_q   <= data_i[DATA_BITS-1:0];
            idx_q    <= '0;
            i_q      <= CLS_W'(1);
            state_q  <= (N_CLASS == 1) ? S_DONE : S_SCAN;
          end
        end
        S_SCAN: begin
          best_q <= best_d;
          idx_q  <= idx_d;
          i_q    <= i_q + 1'b1;
          if (i_q == LAST) state_q <= S_DONE;
        end
        S_DONE: begin
          valid_q  <= 1'b1;
          class_q  <= idx_q;
          max_q    <= best_q;
          onehot_q <= onehot_d;
          if (cnt_q != '1) cnt_q <= cnt_q + 16'd1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o      = (state_q == S_IDLE);
  assign valid_o      = valid_q;
  assign class_o      = class_q;
  assign max_o        = max_q;
  assign onehot_o     = onehot_q;
  assign led_o        = led_q;
  assign result_cnt_o = cnt_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: signed/sticky and unsigned/non-sticky
// instances share stimulus; a third instance covers N_CLASS=1.
module tb_argmax_classifier;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic        clear = 1'b0;
  logic [55:0] data = '0;

  logic        ready_s, vo_s;
  logic [2:0]  cls_s;
  logic [7:0]  max_s;
  logic [6:0]  oh_s;
  logic [7:0]  led_s;
  logic [15:0] cnt_s;

  logic        ready_u, vo_u;
  logic [2:0]  cls_u;
  logic [7:0]  max_u;
  logic [6:0]  oh_u;
  logic [7:0]  led_u;
  logic [15:0] cnt_u;

  logic        valid1 = 1'b0;
  logic        clear1 = 1'b0;
  logic [7:0]  data1 = '0;
  logic        ready_1, vo_1;
  logic [0:0]  cls_1;
  logic [7:0]  max_1;
  logic [0:0]  oh_1;
  logic [1:0]  led_1;
  logic [15:0] cnt_1;

  int checks = 0;
  int failures = 0;
  logic [7:0]  led_s_exp, led_u_exp;
  logic [15:0] cnt_exp;

  always #5 clk = ~clk;

  argmax_classifier dut_s (
    .clk(clk), .reset(reset), .valid_i(valid), .data_i(data), .clear_i(clear),
    .ready_o(ready_s), .valid_o(vo_s), .class_o(cls_s), .max_o(max_s),
    .onehot_o(oh_s), .led_o(led_s), .result_cnt_o(cnt_s)
  );

  argmax_classifier #(.N_CLASS(7), .DATA_BITS(8), .SIGNED(1'b0), .STICKY(1'b0)) dut_u (
    .clk(clk), .reset(reset), .valid_i(valid), .data_i(data), .clear_i(clear),
    .ready_o(ready_u), .valid_o(vo_u), .class_o(cls_u), .max_o(max_u),
    .onehot_o(oh_u), .led_o(led_u), .result_cnt_o(cnt_u)
  );

  argmax_classifier #(.N_CLASS(1), .DATA_BITS(8), .SIGNED(1'b1), .STICKY(1'b1)) dut_1 (
    .clk(clk), .reset(reset), .valid_i(valid1), .data_i(data1), .clear_i(clear1),
    .ready_o(ready_1), .valid_o(vo_1), .class_o(cls_1), .max_o(max_1),
    .onehot_o(oh_1), .led_o(led_1), .result_cnt_o(cnt_1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: first index holding the numerically largest score.
  function automatic void model(input logic [55:0] v, input bit sgn,
                                output int cls, output logic [7:0] mx);
    int best, val;
    logic [7:0] s;
    cls = 0;
    s = v[7:0];
    best = sgn ? int'($signed(s)) : int'(s);
    for (int k = 1; k < 7; k++) begin
      s = v[k*8 +: 8];
      val = sgn ? int'($signed(s)) : int'(s);
      if (val > best) begin
        best = val;
        cls = k;
      end
    end
    mx = v[cls*8 +: 8];
  endfunction

  function automatic void apply_result(input int cs, input int cu);
    led_s_exp = led_s_exp | 8'h80 | 8'(1 << (6 - cs));
    led_u_exp = 8'h80 | 8'(1 << (6 - cu));
    if (cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
  endfunction

  function automatic logic [55:0] pack(input logic [7:0] s0, s1, s2, s3, s4, s5, s6);
    return {s6, s5, s4, s3, s2, s1, s0};
  endfunction

  task automatic do_reset();
    reset = 1'b1; valid = 1'b0; clear = 1'b0; valid1 = 1'b0;
    tick();
    reset = 1'b0;
    led_s_exp = '0; led_u_exp = '0; cnt_exp = '0;
  endtask

  task automatic do_vector(input logic [55:0] v, input string tag);
    int cs, cu, lat;
    logic [7:0] ms, mu;
    model(v, 1'b1, cs, ms);
    model(v, 1'b0, cu, mu);
    checks++;
    if (ready_s !== 1'b1 || ready_u !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready: got s=%b u=%b expected 1", tag, ready_s, ready_u);
    end
    valid = 1'b1; data = v;
    tick();
    valid = 1'b0; data = ~v;
    lat = 0;
    while (vo_s !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    apply_result(cs, cu);
    checks++;
    if (lat != 7) begin
      failures++;
      $display("FAIL %s_latency: got %0d expected 7", tag, lat);
    end
    checks++;
    if (cls_s !== 3'(cs) || max_s !== ms || oh_s !== 7'(1 << cs) ||
        vo_u !== 1'b1 || cls_u !== 3'(cu) || max_u !== mu || oh_u !== 7'(1 << cu)) begin
      failures++;
      $display("FAIL %s_result: got s=%0d/%h/%b u=%b,%0d/%h/%b expected s=%0d/%h u=1,%0d/%h",
               tag, cls_s, max_s, oh_s, vo_u, cls_u, max_u, oh_u, cs, ms, cu, mu);
    end
    checks++;
    if (led_s !== led_s_exp || led_u !== led_u_exp || cnt_s !== cnt_exp || cnt_u !== cnt_exp) begin
      failures++;
      $display("FAIL %s_led_cnt: got led=%b/%b cnt=%0d/%0d expected led=%b/%b cnt=%0d",
               tag, led_s, led_u, cnt_s, cnt_u, led_s_exp, led_u_exp, cnt_exp);
    end
    tick();
    checks++;
    if (vo_s !== 1'b0 || ready_s !== 1'b1 || cls_s !== 3'(cs) || max_s !== ms) begin
      failures++;
      $display("FAIL %s_hold: got vo=%b rdy=%b cls=%0d max=%h expected 0,1,%0d,%h",
               tag, vo_s, ready_s, cls_s, max_s, cs, ms);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; valid = 1'b1; clear = 1'b1; valid1 = 1'b1;
    data = 56'({$urandom(), $urandom()}); data1 = 8'h5A;
    tick();
    tick();
    checks++;
    if (ready_s !== 1'b1 || ready_u !== 1'b1 || ready_1 !== 1'b1 ||
        vo_s !== 1'b0 || vo_u !== 1'b0 || vo_1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got rdy=%b%b%b vo=%b%b%b expected rdy=111 vo=000",
               ready_s, ready_u, ready_1, vo_s, vo_u, vo_1);
    end
    checks++;
    if (cls_s !== '0 || max_s !== '0 || oh_s !== '0 || led_s !== '0 || cnt_s !== '0 ||
        led_u !== '0 || cnt_u !== '0 || max_1 !== '0 || led_1 !== '0 || cnt_1 !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got cls=%0d max=%h oh=%b led=%b cnt=%0d expected all 0",
               cls_s, max_s, oh_s, led_s, cnt_s);
    end
    reset = 1'b0; valid = 1'b0; clear = 1'b0; valid1 = 1'b0;
    led_s_exp = '0; led_u_exp = '0; cnt_exp = '0;
  endtask

  task automatic test_directed();
    do_reset();
    do_vector(pack(8'd10, 8'd20, 8'd5, 8'hFD, 8'd20, 8'd0, 8'd1), "tie");
    checks++;
    if (cls_s !== 3'd1 || max_s !== 8'h14 || oh_s !== 7'b0000010 || led_s !== 8'b1010_0000) begin
      failures++;
      $display("FAIL tie_fixed: got cls=%0d max=%h oh=%b led=%b expected 1,14,0000010,10100000",
               cls_s, max_s, oh_s, led_s);
    end
    do_vector({7{8'h80}}, "all80");
    checks++;
    if (cls_s !== 3'd0 || max_s !== 8'h80 || cls_u !== 3'd0) begin
      failures++;
      $display("FAIL all80_fixed: got cls=%0d max=%h ucls=%0d expected 0,80,0", cls_s, max_s, cls_u);
    end
    do_vector(pack(8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h7F, 8'h7F, 8'h7F), "polarity");
    checks++;
    if (cls_s !== 3'd0 || cls_u !== 3'd3) begin
      failures++;
      $display("FAIL polarity_fixed: got signed=%0d unsigned=%0d expected 0,3", cls_s, cls_u);
    end
  endtask

  task automatic test_sticky_clear();
    do_reset();
    do_vector(pack(8'd1, 8'd50, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6), "cls1");
    do_vector(pack(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd60), "cls6");
    checks++;
    if (led_s !== 8'b1010_0001 || led_u !== 8'b1000_0001) begin
      failures++;
      $display("FAIL sticky_led: got s=%b u=%b expected 10100001,10000001", led_s, led_u);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    led_s_exp = '0; led_u_exp = '0;
    checks++;
    if (led_s !== 8'h00 || led_u !== 8'h00 || cls_s !== 3'd6 || cnt_s !== 16'd2 || ready_s !== 1'b1) begin
      failures++;
      $display("FAIL clear_led: got led=%b/%b cls=%0d cnt=%0d rdy=%b expected 0,0,6,2,1",
               led_s, led_u, cls_s, cnt_s, ready_s);
    end
  endtask

  task automatic test_clear_at_done();
    logic [55:0] v;
    int cs, cu;
    logic [7:0] ms, mu;
    v = pack(8'd3, 8'd4, 8'd90, 8'd1, 8'd2, 8'd0, 8'd7);
    model(v, 1'b1, cs, ms);
    model(v, 1'b0, cu, mu);
    valid = 1'b1; data = v;
    tick();
    valid = 1'b0;
    repeat (6) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    led_s_exp = 8'h80 | 8'(1 << (6 - cs));
    led_u_exp = 8'h80 | 8'(1 << (6 - cu));
    cnt_exp = cnt_exp + 16'd1;
    checks++;
    if (vo_s !== 1'b1 || led_s !== led_s_exp || led_u !== led_u_exp) begin
      failures++;
      $display("FAIL clear_done: got vo=%b led=%b/%b expected 1,%b/%b",
               vo_s, led_s, led_u, led_s_exp, led_u_exp);
    end
  endtask

  task automatic test_random();
    logic [55:0] v;
    logic [7:0] pick [4];
    pick[0] = 8'h80; pick[1] = 8'h7F; pick[2] = 8'h00; pick[3] = 8'hFF;
    for (int n = 0; n < 6; n++) begin
      v = 56'({$urandom(), $urandom()});
      do_vector(v, "rand");
    end
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 7; k++) v[k*8 +: 8] = pick[$urandom_range(0, 3)];
      do_vector(v, "randtie");
    end
  endtask

  task automatic test_back_to_back();
    logic [55:0] q[$];
    logic [55:0] v, acc;
    int pulses, last, cs, cu;
    logic [7:0] ms, mu;
    do_reset();
    pulses = 0;
    last = -1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      valid = (cyc < 40);
      v = 56'({$urandom(), $urandom()});
      data = v;
      if (valid && ready_s === 1'b1) q.push_back(v);
      tick();
      if (vo_s === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra: got valid_o at cycle %0d expected no pending vector", cyc);
        end else begin
          acc = q.pop_front();
          model(acc, 1'b1, cs, ms);
          model(acc, 1'b0, cu, mu);
          apply_result(cs, cu);
          if (cls_s !== 3'(cs) || max_s !== ms || cls_u !== 3'(cu) || max_u !== mu) begin
            failures++;
            $display("FAIL b2b_result: got %0d/%h u=%0d/%h expected %0d/%h u=%0d/%h",
                     cls_s, max_s, cls_u, max_u, cs, ms, cu, mu);
          end
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 8) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d cycles expected 8", cyc - last);
          end
        end
        last = cyc;
        pulses++;
      end
    end
    valid = 1'b0;
    checks++;
    if (pulses != 5 || q.size() != 0 || cnt_s !== cnt_exp || led_s !== led_s_exp) begin
      failures++;
      $display("FAIL b2b_count: got pulses=%0d pending=%0d cnt=%0d led=%b expected 5,0,%0d,%b",
               pulses, q.size(), cnt_s, led_s, cnt_exp, led_s_exp);
    end
  endtask

  task automatic test_reset_mid_scan();
    int spurious;
    do_vector(pack(8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3), "pre_abort");
    valid = 1'b1; data = pack(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
    tick();
    valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    led_s_exp = '0; led_u_exp = '0; cnt_exp = '0;
    checks++;
    if (ready_s !== 1'b1 || vo_s !== 1'b0 || cls_s !== '0 || max_s !== '0 || oh_s !== '0 ||
        led_s !== '0 || cnt_s !== '0) begin
      failures++;
      $display("FAIL abort_outputs: got rdy=%b vo=%b cls=%0d max=%h oh=%b led=%b cnt=%0d expected 1,0,0,0,0,0,0",
               ready_s, vo_s, cls_s, max_s, oh_s, led_s, cnt_s);
    end
    spurious = 0;
    repeat (12) begin
      tick();
      if (vo_s !== 1'b0 || vo_u !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      failures++;
      $display("FAIL abort_novalid: got %0d valid_o cycles expected 0", spurious);
    end
  endtask

  task automatic test_single_class();
    logic [7:0] v;
    v = 8'($urandom_range(1, 255));
    valid1 = 1'b1; data1 = v;
    tick();
    valid1 = 1'b0; data1 = ~v;
    checks++;
    if (ready_1 !== 1'b0 || vo_1 !== 1'b0) begin
      failures++;
      $display("FAIL n1_busy: got rdy=%b vo=%b expected 0,0", ready_1, vo_1);
    end
    tick();
    checks++;
    if (vo_1 !== 1'b1 || cls_1 !== 1'b0 || max_1 !== v || oh_1 !== 1'b1 ||
        led_1 !== 2'b11 || cnt_1 !== 16'd1) begin
      failures++;
      $display("FAIL n1_result: got vo=%b cls=%0d max=%h oh=%b led=%b cnt=%0d expected 1,0,%h,1,11,1",
               vo_1, cls_1, max_1, oh_1, led_1, cnt_1, v);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_sticky_clear();
    test_clear_at_done();
    test_random();
    test_back_to_back();
    test_reset_mid_scan();
    test_single_class();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
